// File: rtl/snoop_pkg.sv
// Shared definitions for the MESI snooping bus scheduler.
//   step_e  : step codes broadcast to every cache on the `step` bus.
//   state_e : scheduler state encoding.
//   step_of : maps a scheduler state to the step code it broadcasts.
package snoop_pkg;

    typedef enum logic [2:0] {
        STEP_NONE   = 3'b000,
        STEP_SNOOP  = 3'b001,
        STEP_LOOKUP = 3'b010,
        STEP_SUPPLY = 3'b011,
        STEP_UPDATE = 3'b100,
        STEP_FILL   = 3'b101,
        STEP_FIN    = 3'b110
    } step_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_FIN,
        ST_CLR
    } state_e;

    function automatic step_e step_of(input state_e s);
        case (s)
            ST_S1:   return STEP_SNOOP;
            ST_S2:   return STEP_LOOKUP;
            ST_S3:   return STEP_SUPPLY;
            ST_S4:   return STEP_UPDATE;
            ST_S5:   return STEP_FILL;
            ST_FIN:  return STEP_FIN;
            default: return STEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snoop_bus_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-processor request bits.
//   last  : index of the most recently granted processor; search starts
//           at last+1 and wraps, so `last` itself has lowest priority.
//   grant : one-hot winner (zero when no request).
//   valid : at least one request present.
module rr_arbiter
    import snoop_pkg::*;
#(
    parameter int N_PROC = 3,
    localparam int IW    = $clog2(N_PROC)
) (
    input  logic [N_PROC-1:0] req,
    input  logic [IW-1:0]     last,
    output logic [N_PROC-1:0] grant,
    output logic              valid
);

    always_comb begin
        logic [IW-1:0] idx;
        idx   = '0;
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= N_PROC; i++) begin
            idx = IW'((int'(last) + i) % N_PROC);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_scheduler.sv
// Bus arbiter and step sequencer for the MESI snooping subsystem.
//   clock, reset          : rising-edge clock, asynchronous active-low reset.
//   req                   : per-processor pending-instruction request (level).
//   step1Done..step5Done  : per-cache sticky step-complete flags.
//   instrDone             : per-cache instruction-complete flag.
//   step                  : step code broadcast to all caches.
//   grant                 : one-hot bus owner, zero when idle.
//   cacheClr, ack         : one-cycle pulse at the end of every transaction.
//   busy                  : high whenever the scheduler is not idle.
//   timeoutErr            : sticky abort indicator.
//   xferCount             : completed (non-aborted) transactions, wrapping.
// All outputs are registered from next-state values, so they change on the
// same edge as the state they describe.
module snoop_bus_scheduler
    import snoop_pkg::*;
#(
    parameter int N_PROC  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PROC-1:0] req,
    input  logic [N_PROC-1:0] step1Done,
    input  logic [N_PROC-1:0] step2Done,
    input  logic [N_PROC-1:0] step3Done,
    input  logic [N_PROC-1:0] step4Done,
    input  logic [N_PROC-1:0] step5Done,
    input  logic [N_PROC-1:0] instrDone,
    output logic [2:0]        step,
    output logic [N_PROC-1:0] grant,
    output logic              cacheClr,
    output logic              ack,
    output logic              busy,
    output logic              timeoutErr,
    output logic [7:0]        xferCount
);

    localparam int IW = $clog2(N_PROC);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the edge that would complete the TIMEOUT-th cycle in a step.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d, nxt_state;
    step_e             step_q, step_d;
    logic [N_PROC-1:0] grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d, g_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        xfer_q, xfer_d;
    logic              clr_q, clr_d, busy_q, busy_d, terr_q, terr_d;
    logic              cond, timed;
    logic [N_PROC-1:0] arb_grant;
    logic              arb_valid;

    rr_arbiter #(.N_PROC(N_PROC)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (grant_q[i]) g_idx = IW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        nxt_state = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        xfer_d    = xfer_q;
        terr_d    = terr_q;
        cnt_d     = '0;
        cond      = 1'b0;
        timed     = 1'b0;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_ARB;
            ST_ARB: begin
                // A request that vanished before arbitration just returns to idle.
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = ST_S1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1: begin timed = 1'b1; cond = &step1Done; nxt_state = ST_S2; end
            ST_S2: begin
                timed = 1'b1;
                // Read hit short path takes precedence over the miss path.
                if (|(instrDone & grant_q)) begin
                    cond      = 1'b1;
                    nxt_state = ST_FIN;
                end else begin
                    cond      = |(step2Done & grant_q);
                    nxt_state = ST_S3;
                end
            end
            ST_S3:  begin timed = 1'b1; cond = &step3Done;             nxt_state = ST_S4;  end
            ST_S4:  begin timed = 1'b1; cond = &step4Done;             nxt_state = ST_S5;  end
            ST_S5:  begin timed = 1'b1; cond = |(step5Done & grant_q); nxt_state = ST_FIN; end
            ST_FIN: begin timed = 1'b1; cond = |(instrDone & grant_q); nxt_state = ST_CLR; end
            ST_CLR: begin
                last_d  = g_idx;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timed) begin
            if (cond) begin
                state_d = nxt_state;
                // Only the normal FIN exit counts; aborts reach CLR from elsewhere.
                if (state_q == ST_FIN) xfer_d = xfer_q + 8'd1;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                state_d = ST_CLR;
                terr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_NONE;
            grant_q <= '0;
            last_q  <= IW'(N_PROC - 1);
            cnt_q   <= '0;
            xfer_q  <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_of(state_d);
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            xfer_q  <= xfer_d;
            clr_q   <= (state_d == ST_CLR);
            busy_q  <= (state_d != ST_IDLE);
            terr_q  <= terr_d;
        end
    end

    assign step       = step_q;
    assign grant      = grant_q;
    assign cacheClr   = clr_q;
    assign ack        = clr_q;
    assign busy       = busy_q;
    assign timeoutErr = terr_q;
    assign xferCount  = xfer_q;

endmodule

// File: tb/tb_snoop_bus_scheduler.sv
module tb_snoop_bus_scheduler;

    localparam int N = 3;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] step1Done, step2Done, step3Done, step4Done, step5Done, instrDone;
    logic [2:0]   step;
    logic [N-1:0] grant;
    logic         cacheClr, ack, busy, timeoutErr;
    logic [7:0]   xferCount;

    snoop_bus_scheduler #(.N_PROC(N), .TIMEOUT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .step1Done  (step1Done),
        .step2Done  (step2Done),
        .step3Done  (step3Done),
        .step4Done  (step4Done),
        .step5Done  (step5Done),
        .instrDone  (instrDone),
        .step       (step),
        .grant      (grant),
        .cacheClr   (cacheClr),
        .ack        (ack),
        .busy       (busy),
        .timeoutErr (timeoutErr),
        .xferCount  (xferCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache behaviour knobs.
    bit           hit;
    logic [N-1:0] hold3;

    // Cache model: each cache registers its done flag one edge after it
    // sees the step code; flags are sticky until cacheClr or reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            step1Done <= '0; step2Done <= '0; step3Done <= '0;
            step4Done <= '0; step5Done <= '0; instrDone <= '0;
        end else if (cacheClr) begin
            step1Done <= '0; step2Done <= '0; step3Done <= '0;
            step4Done <= '0; step5Done <= '0; instrDone <= '0;
        end else begin
            case (step)
                3'b001: step1Done <= '1;
                3'b010: if (hit) instrDone <= instrDone | grant;
                        else     step2Done <= step2Done | grant;
                3'b011: step3Done <= ~hold3;
                3'b100: step4Done <= '1;
                3'b101: step5Done <= step5Done | grant;
                3'b110: instrDone <= instrDone | grant;
                default: ;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations.
    logic [23:0]  trace;
    int           ack_edge;
    logic [N-1:0] gnt_seen;
    bit           gnt_bad, busy_bad;
    logic         clr_at_ack, terr_at_ack;
    logic [7:0]   xfer_at_ack;

    // Drives req just after an edge, then samples 1 time unit after each
    // following edge until ack. Edge 1 is the first edge that sees req, so
    // the cycle req is raised in is cycle 1 and ack seen after edge k lies in cycle k+1.
    task automatic run_txn(input logic [N-1:0] r, input bit keep);
        logic [2:0] last_step;
        last_step = 3'b000;
        req       = r;
        trace     = '0;
        ack_edge  = -1;
        gnt_seen  = '0;
        gnt_bad   = 1'b0;
        busy_bad  = 1'b0;
        for (int c = 1; c <= 60 && ack_edge < 0; c++) begin
            @(posedge clock); #1;
            if (step != last_step && step != 3'b000) trace = {trace[20:0], step};
            last_step = step;
            if (grant != '0) begin
                if (gnt_seen == '0) gnt_seen = grant;
                else if (grant != gnt_seen) gnt_bad = 1'b1;
                if (!busy) busy_bad = 1'b1;
            end
            if (ack) begin
                ack_edge    = c;
                clr_at_ack  = cacheClr;
                terr_at_ack = timeoutErr;
                xfer_at_ack = xferCount;
            end
        end
        check_eq("ack_seen", 32'(ack_edge >= 0), 1);
        if (!keep) req = '0;
    endtask

    task automatic reset_dut();
        req   = '0;
        hit   = 1'b0;
        hold3 = '0;
        #2 reset = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
    endtask

    logic [N-1:0] exp_gnt [4];
    bit           reached;

    initial begin
        reset = 1'b0;
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;

        // Reset values.
        reset_dut();
        check_eq("rst_step", step, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_clr", cacheClr, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_terr", timeoutErr, 0);
        check_eq("rst_xfer", xferCount, 0);

        // Single read hit by processor 1: steps 001, 010, 110 only.
        hit = 1'b1;
        run_txn(3'b010, 0);
        check_eq("hit_trace", trace, 24'o126);
        check_eq("hit_grant", gnt_seen, 3'b010);
        check_eq("hit_clr", clr_at_ack, 1);
        check_eq("hit_xfer", xfer_at_ack, 1);
        @(posedge clock); #1;
        check_eq("hit_clr_width", cacheClr, 0);
        check_eq("hit_idle_grant", grant, 0);

        // Write miss by processor 0: full sequence, ack in cycle 15.
        hit = 1'b0;
        run_txn(3'b001, 0);
        check_eq("miss_trace", trace, 24'o123456);
        check_eq("miss_ack_cycle", ack_edge + 1, 15);
        check_eq("miss_grant", gnt_seen, 3'b001);
        check_eq("miss_grant_stable", gnt_bad, 0);
        check_eq("miss_clr", clr_at_ack, 1);
        check_eq("miss_xfer", xfer_at_ack, 2);
        @(posedge clock); #1;
        check_eq("miss_clr_width", cacheClr, 0);

        // Contention: all three requesting, served round-robin from index 0.
        reset_dut();
        hit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(3'b111, 1);
            check_eq($sformatf("rr_grant%0d", k), gnt_seen, exp_gnt[k]);
            check_eq($sformatf("rr_busy%0d", k), busy_bad, 0);
        end
        req = '0;
        @(posedge clock); #1;

        // Counter wrap over 256 hit transactions.
        reset_dut();
        hit = 1'b1;
        for (int k = 0; k < 256; k++) begin
            run_txn(3'b100, 0);
            @(posedge clock); #1;
            if (k == 254) check_eq("wrap_255", xferCount, 255);
        end
        check_eq("wrap_zero", xferCount, 0);
        check_eq("wrap_terr", timeoutErr, 0);

        // Partial snoop: cache 2 never completes step 3 -> abort after 15 cycles in S3.
        // S3 is entered at edge 6, so the abort lands on edge 21.
        hit   = 1'b0;
        hold3 = 3'b100;
        run_txn(3'b001, 0);
        check_eq("to_trace", trace, 24'o123);
        check_eq("to_ack_edge", ack_edge, 21);
        check_eq("to_terr", terr_at_ack, 1);
        check_eq("to_xfer", xfer_at_ack, 0);
        hold3 = '0;
        @(posedge clock); #1;
        check_eq("to_terr_sticky", timeoutErr, 1);
        check_eq("to_xfer_after", xferCount, 0);

        // Asynchronous reset while in S4.
        req     = 3'b001;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(posedge clock); #1;
            if (step == 3'b100) reached = 1'b1;
        end
        check_eq("s4_reached", reached, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("areset_step", step, 0);
        check_eq("areset_grant", grant, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_terr", timeoutErr, 0);
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        run_txn(3'b100, 0);
        check_eq("areset_regrant", gnt_seen, 3'b100);
        check_eq("areset_trace", trace, 24'o123456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
